// File: rtl/coordenador_raio_busca.sv
// coordenador_raio_busca: starts the four quadrant search engines, grows the radius pass by pass and picks the closest target
module coordenador_raio_busca #(
   parameter int TamanhoMalha     = 20,
   parameter int tamanhoDistancia = 8,
   parameter int NumQuadrantes    = 4,
   parameter int RaioInicial      = 1,
   parameter int RaioMaximo       = 19
) (
   input  logic                                             clock,
   input  logic                                             reset,
   input  logic                                             iniciar,
   input  logic [tamanhoDistancia-1:0]                      posicaoAtualnoEixoX,
   input  logic [tamanhoDistancia-1:0]                      posicaoAtualnoEixoY,
   input  logic [NumQuadrantes-1:0]                         acabouCalculoLocal,
   input  logic [NumQuadrantes-1:0]                         operacaoFinalizada,
   input  logic [NumQuadrantes-1:0][tamanhoDistancia-1:0]   candidatoAtual,
   input  logic [NumQuadrantes-1:0][tamanhoDistancia-1:0]   coordenadaCandidatoX,
   input  logic [NumQuadrantes-1:0][tamanhoDistancia-1:0]   coordenadaCandidatoY,
   output logic                                             enable,
   output logic [tamanhoDistancia-1:0]                      raio,
   output logic                                             raioAtualizado,
   output logic [tamanhoDistancia-1:0]                      posicaoX,
   output logic [tamanhoDistancia-1:0]                      posicaoY,
   output logic                                             ocupado,
   output logic                                             concluido,
   output logic                                             encontrado,
   output logic [tamanhoDistancia-1:0]                      destinoX,
   output logic [tamanhoDistancia-1:0]                      destinoY,
   output logic [tamanhoDistancia-1:0]                      distanciaMinima,
   output logic [$clog2(NumQuadrantes)-1:0]                 quadranteEscolhido
);
   localparam int W  = tamanhoDistancia;
   localparam int QW = $clog2(NumQuadrantes);
   // a radius past the grid edge cannot reveal new cells, so the last pass is bounded by both limits
   localparam int RaioLimite = (RaioMaximo < TamanhoMalha) ? RaioMaximo : TamanhoMalha - 1;

   typedef enum logic [2:0] {IDLE, GUARDA, AGUARDA, ASSENTA, DECIDE, ATUALIZA, FINALIZA} estado_t;

   estado_t         state_q, state_d;
   logic            guarda_q, guarda_d;
   logic [W-1:0]    raio_q, raio_d;
   logic [W-1:0]    px_q, px_d, py_q, py_d;
   logic            encontrado_q, encontrado_d;
   logic [W-1:0]    dx_q, dx_d, dy_q, dy_d, dist_q, dist_d;
   logic [QW-1:0]   quad_q, quad_d;
   logic            best_valid;
   logic [W-1:0]    best_dist;
   logic [QW-1:0]   best_idx;

   // minimum valid candidate distance; strict compare keeps the lowest index on ties
   always_comb begin
      best_valid = 1'b0;
      best_dist  = '1;
      best_idx   = '0;
      for (int i = 0; i < NumQuadrantes; i++) begin
         if (candidatoAtual[i] != '1 && (!best_valid || candidatoAtual[i] < best_dist)) begin
            best_valid = 1'b1;
            best_dist  = candidatoAtual[i];
            best_idx   = QW'(i);
         end
      end
   end

   // next-state and datapath updates of the search sequence
   always_comb begin
      state_d      = state_q;
      guarda_d     = 1'b0;
      raio_d       = raio_q;
      px_d         = px_q;
      py_d         = py_q;
      encontrado_d = encontrado_q;
      dx_d         = dx_q;
      dy_d         = dy_q;
      dist_d       = dist_q;
      quad_d       = quad_q;
      case (state_q)
         IDLE: begin
            if (iniciar) begin
               px_d         = posicaoAtualnoEixoX;
               py_d         = posicaoAtualnoEixoY;
               raio_d       = W'(RaioInicial);
               encontrado_d = 1'b0;
               dx_d         = '0;
               dy_d         = '0;
               dist_d       = '1;
               quad_d       = '0;
               state_d      = GUARDA;
            end
         end
         GUARDA: begin
            guarda_d = ~guarda_q;
            state_d  = guarda_q ? AGUARDA : GUARDA;
         end
         AGUARDA:  state_d = (&acabouCalculoLocal) ? ASSENTA : AGUARDA;
         ASSENTA:  state_d = DECIDE;
         DECIDE: begin
            if (best_valid) begin
               dx_d         = coordenadaCandidatoX[best_idx];
               dy_d         = coordenadaCandidatoY[best_idx];
               dist_d       = best_dist;
               quad_d       = best_idx;
               encontrado_d = 1'b1;
               state_d      = FINALIZA;
            end else if ((&operacaoFinalizada) || raio_q == W'(RaioLimite)) begin
               encontrado_d = 1'b0;
               state_d      = FINALIZA;
            end else begin
               raio_d  = raio_q + 1'b1;
               state_d = ATUALIZA;
            end
         end
         ATUALIZA: state_d = GUARDA;
         FINALIZA: state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // state and result registers, cleared asynchronously
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         guarda_q     <= 1'b0;
         raio_q       <= '0;
         px_q         <= '0;
         py_q         <= '0;
         encontrado_q <= 1'b0;
         dx_q         <= '0;
         dy_q         <= '0;
         dist_q       <= '1;
         quad_q       <= '0;
      end else begin
         state_q      <= state_d;
         guarda_q     <= guarda_d;
         raio_q       <= raio_d;
         px_q         <= px_d;
         py_q         <= py_d;
         encontrado_q <= encontrado_d;
         dx_q         <= dx_d;
         dy_q         <= dy_d;
         dist_q       <= dist_d;
         quad_q       <= quad_d;
      end
   end

   assign ocupado            = state_q != IDLE && state_q != FINALIZA;
   assign enable             = ocupado;
   assign raioAtualizado     = state_q == ATUALIZA || state_q == FINALIZA;
   assign concluido          = state_q == FINALIZA;
   assign raio               = raio_q;
   assign posicaoX           = px_q;
   assign posicaoY           = py_q;
   assign encontrado         = encontrado_q;
   assign destinoX           = dx_q;
   assign destinoY           = dy_q;
   assign distanciaMinima    = dist_q;
   assign quadranteEscolhido = quad_q;
endmodule

// File: tb/tb_coordenador_raio_busca.sv
// tb_coordenador_raio_busca: engine models plus a pass-by-pass reference of the radius search
module tb_coordenador_raio_busca;
   logic            clock = 1'b0;
   logic            reset;
   logic            iniciar;
   logic [7:0]      posX, posY;
   logic [3:0]      acab, opfin;
   logic [3:0][7:0] cand, cx, cy;
   logic            enable, raioAtualizado, ocupado, concluido, encontrado;
   logic [7:0]      raio, posicaoX, posicaoY, destinoX, destinoY, distanciaMinima;
   logic [1:0]      quadranteEscolhido;

   int n_checks = 0;
   int n_fails  = 0;
   int found_r[4];
   int dv[4], cxv[4], cyv[4];
   int fin_r;
   int cnt = 0;
   logic oc_prev = 1'b0;

   coordenador_raio_busca dut (
      .clock(clock), .reset(reset), .iniciar(iniciar),
      .posicaoAtualnoEixoX(posX), .posicaoAtualnoEixoY(posY),
      .acabouCalculoLocal(acab), .operacaoFinalizada(opfin),
      .candidatoAtual(cand), .coordenadaCandidatoX(cx), .coordenadaCandidatoY(cy),
      .enable(enable), .raio(raio), .raioAtualizado(raioAtualizado),
      .posicaoX(posicaoX), .posicaoY(posicaoY), .ocupado(ocupado),
      .concluido(concluido), .encontrado(encontrado),
      .destinoX(destinoX), .destinoY(destinoY),
      .distanciaMinima(distanciaMinima), .quadranteEscolhido(quadranteEscolhido)
   );

   always #5 clock = ~clock;

   // engine models: pass done 5 cycles after start or radius update; candidates from the programmed radius on
   always @(negedge clock) begin
      if (!reset) begin
         cnt  = 0;
         acab = '0;
      end else if (raioAtualizado || (ocupado && !oc_prev)) begin
         acab = '0;
         cnt  = 5;
      end else if (cnt > 0) begin
         cnt = cnt - 1;
         if (cnt == 0) acab = '1;
      end
      oc_prev = ocupado;
      for (int i = 0; i < 4; i++) begin
         cand[i] = (int'(raio) >= found_r[i]) ? 8'(dv[i]) : 8'hFF;
         cx[i]   = 8'(cxv[i]);
         cy[i]   = 8'(cyv[i]);
      end
      opfin = (int'(raio) >= fin_r) ? 4'hF : 4'h0;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic clear_engines();
      for (int i = 0; i < 4; i++) begin
         found_r[i] = 99;
         dv[i]      = 0;
         cxv[i]     = 0;
         cyv[i]     = 0;
      end
      fin_r = 99;
   endtask

   // one full search from (x,y); expectations come from walking the radii 1..19 in the model
   task automatic run(input int x, input int y, input bit poke);
      int  er = 19;
      bit  ef = 0;
      int  w  = -1;
      int  pulses = 0;
      bit  done = 0;
      bit  bad = 0;
      for (int r = 1; r <= 19; r++) begin
         bit any = 0;
         for (int i = 0; i < 4; i++) if (found_r[i] <= r) any = 1;
         if (any) begin er = r; ef = 1; break; end
         if (fin_r <= r) begin er = r; break; end
      end
      for (int i = 0; i < 4; i++)
         if (ef && found_r[i] <= er && (w < 0 || dv[i] < dv[w])) w = i;
      @(negedge clock);
      posX = 8'(x); posY = 8'(y); iniciar = 1'b1;
      @(negedge clock);
      iniciar = 1'b0; posX = 8'($urandom); posY = 8'($urandom);
      chk("raio_ini", raio, 1);
      for (int cyc = 0; cyc < 1000 && !done; cyc++) begin
         if (concluido) done = 1;
         else begin
            if (!ocupado || !enable || posicaoX != 8'(x) || posicaoY != 8'(y)) bad = 1;
            if (raioAtualizado) begin
               pulses++;
               chk("raio_step", raio, pulses + 1);
            end
            iniciar = (poke && cyc == 3);
            @(negedge clock);
         end
      end
      iniciar = 1'b0;
      chk("timeout", done, 1);
      chk("busy_stable", bad, 0);
      chk("pulses", pulses, er - 1);
      chk("raio_final", raio, er);
      chk("encontrado", encontrado, ef);
      chk("destinoX", destinoX, ef ? cxv[w] : 0);
      chk("destinoY", destinoY, ef ? cyv[w] : 0);
      chk("distancia", distanciaMinima, ef ? dv[w] : 255);
      chk("quadrante", quadranteEscolhido, ef ? w : 0);
      chk("fin_pulse", {raioAtualizado, ocupado, enable}, 3'b100);
      @(negedge clock);
      chk("conc_once", {concluido, raioAtualizado, ocupado}, 3'b000);
      chk("held", encontrado, ef);
   endtask

   initial begin
      clear_engines();
      reset = 1'b0; iniciar = 1'b0; posX = '0; posY = '0;
      repeat (3) @(negedge clock);
      chk("rst_raio", raio, 0);
      chk("rst_dist", distanciaMinima, 8'hFF);
      chk("rst_flags", {enable, ocupado, concluido, encontrado, raioAtualizado}, 0);
      reset = 1'b1;
      // target on the first pass
      found_r[2] = 1; dv[2] = 3; cxv[2] = 9; cyv[2] = 12;
      run(10, 10, 0);
      // target only from radius 3
      clear_engines();
      found_r[0] = 3; dv[0] = 3; cxv[0] = 8; cyv[0] = 10;
      run(10, 10, 0);
      // tie between engines 1 and 3
      clear_engines();
      found_r[1] = 1; dv[1] = 4; cxv[1] = 11; cyv[1] = 7;
      found_r[3] = 1; dv[3] = 4; cxv[3] = 13; cyv[3] = 6;
      run(10, 10, 0);
      // engine 0 closer than engine 3
      clear_engines();
      found_r[0] = 1; dv[0] = 2; cxv[0] = 9; cyv[0] = 9;
      found_r[3] = 1; dv[3] = 5; cxv[3] = 14; cyv[3] = 12;
      run(10, 10, 0);
      // nothing ever found: climb to the maximum radius
      clear_engines();
      run(10, 10, 0);
      // engines all give up at radius 2
      clear_engines();
      fin_r = 2;
      run(5, 5, 0);
      // asynchronous reset in the middle of the radius-4 pass
      clear_engines();
      @(negedge clock);
      posX = 8'd10; posY = 8'd10; iniciar = 1'b1;
      @(negedge clock);
      iniciar = 1'b0;
      for (int k = 0; k < 200 && raio != 8'd4; k++) @(negedge clock);
      chk("reach_r4", raio, 4);
      repeat (3) @(negedge clock);
      #2 reset = 1'b0;
      #1;
      chk("async_raio", raio, 0);
      chk("async_pos", {posicaoX, posicaoY}, 0);
      chk("async_dist", distanciaMinima, 8'hFF);
      chk("async_flags", {enable, ocupado, concluido, encontrado, raioAtualizado}, 0);
      @(negedge clock);
      reset = 1'b1;
      found_r[1] = 2; dv[1] = 7; cxv[1] = 1; cyv[1] = 18;
      run(0, 19, 1);
      // randomized scenarios
      for (int t = 0; t < 12; t++) begin
         for (int i = 0; i < 4; i++) begin
            found_r[i] = $urandom_range(1, 25);
            dv[i]      = $urandom_range(0, 254);
            cxv[i]     = $urandom_range(0, 19);
            cyv[i]     = $urandom_range(0, 19);
         end
         fin_r = $urandom_range(1, 25);
         run($urandom_range(0, 19), $urandom_range(0, 19), t[0]);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule

// File: doc/coordenador_raio_busca.md
Name: coordenador_raio_busca

Overview:
- Initiator and arbiter for the four quadrant search engines (esquerda/direita × frente/trás).
- Latches the current position and drives `enable` and `raio` to the engines.
- Grows the radius one step per pass, using the engines' `acabouCalculoLocal` / `operacaoFinalizada` / `raioAtualizado` handshake.
- At the end of a pass, picks the closest grid cell of value 3 among the engines' candidates and reports it to the path planner.

Parameters:
- `TamanhoMalha`, 20, grid side length in cells.
- `tamanhoDistancia`, 8, bit width of coordinates, radius and distance.
- `NumQuadrantes`, 4, number of search engines arbitrated.
- `RaioInicial`, 1, radius issued on start.
- `RaioMaximo`, 19, last radius tried before giving up.

Ports:
- `clock` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low reset (0 = reset).
- `iniciar` in 1: single-cycle start request.
- `posicaoAtualnoEixoX` in W: current X; latched on accepted start.
- `posicaoAtualnoEixoY` in W: current Y; latched on accepted start.
- `acabouCalculoLocal` in NumQuadrantes: per-engine "pass done" flag.
- `operacaoFinalizada` in NumQuadrantes: per-engine "finished (found or all limits hit)" flag.
- `candidatoAtual` in NumQuadrantes×W: per-engine best distance; all-ones means none.
- `coordenadaCandidatoX` in NumQuadrantes×W: per-engine candidate X.
- `coordenadaCandidatoY` in NumQuadrantes×W: per-engine candidate Y.
- `enable` out 1: engine enable.
- `raio` out W: current search radius.
- `raioAtualizado` out 1: single-cycle pulse releasing engines from their wait state.
- `posicaoX` out W: latched position X, broadcast to engines.
- `posicaoY` out W: latched position Y, broadcast to engines.
- `ocupado` out 1: high from accepted start until `concluido`.
- `concluido` out 1: single-cycle result-valid pulse.
- `encontrado` out 1: a target was found; valid with `concluido`, held until next start.
- `destinoX` out W: chosen X; valid with `concluido`, held until next start.
- `destinoY` out W: chosen Y; valid with `concluido`, held until next start.
- `distanciaMinima` out W: chosen distance; valid with `concluido`, held until next start.
- `quadranteEscolhido` out clog2(NumQuadrantes): index of the winning engine.

Behaviour:
- Reset (`reset`=0, any state, mid-search included): state IDLE; all outputs 0; `distanciaMinima` = all-ones; pending operation discarded.
- IDLE
  - `iniciar`=1 latches the position, sets `raio`=RaioInicial, `enable`=1, `ocupado`=1, `encontrado`=0, then goes to GUARDA.
  - `iniciar` while not in IDLE is ignored.
- GUARDA
  - Fixed 2 cycles, so engines can clear stale `acabouCalculoLocal` after a start or `raioAtualizado`.
  - Then go to AGUARDA.
- AGUARDA
  - Stay until `&acabouCalculoLocal`=1; then go to ASSENTA.
  - No timeout.
  - Engines already finished keep `acabouCalculoLocal` high and count as done.
- ASSENTA: 1 cycle, so engines can leave their radius stage and present `operacaoFinalizada`. Then go to DECIDE.
- DECIDE (combinational arbitration, registered result)
  - Engine i is valid when `candidatoAtual[i]` ≠ all-ones.
  - Winner is the minimum unsigned `candidatoAtual` among valid engines; ties go to the lowest index.
  - If any engine is valid: register `destinoX`/`destinoY`, `distanciaMinima`, `quadranteEscolhido`, set `encontrado`=1, go to FINALIZA.
  - Else if `&operacaoFinalizada`=1 or `raio`==RaioMaximo: `encontrado`=0, go to FINALIZA.
  - Else go to ATUALIZA.
- ATUALIZA (1 cycle)
  - `raio` <= `raio`+1 and `raioAtualizado`=1 in the same cycle; engines sample the new radius with the pulse.
  - Then go to GUARDA.
- FINALIZA (1 cycle)
  - `raioAtualizado`=1, `enable`=0, `concluido`=1, `ocupado`=0.
  - Then go to IDLE.
  - A start is accepted again the next cycle.
- Arithmetic
  - `raio` never wraps; RaioMaximo bounds it. RaioMaximo must be < 2^W − 1.
  - Distances are compared as W-bit unsigned.
- Outputs change only on clock edges; `raioAtualizado` and `concluido` are never high for more than 1 cycle.
- `posicaoX`/`posicaoY` are stable for the whole search even if the inputs change.

Test Plan:
- Engine models: the bench drives `acabouCalculoLocal` 5 cycles after each `raioAtualizado`/start, with no candidates until a programmed radius.
- Start at (10,10); engine 2 reports `candidatoAtual`=3 at (9,12) on the radius-1 pass → no `raioAtualizado` before FINALIZA; `concluido` pulse with `encontrado`=1, `destinoX`=9, `destinoY`=12, `quadranteEscolhido`=2, `raio`=1.
- No candidate until radius 3 → exactly two ATUALIZA pulses, `raio` sequence 1,2,3, then `concluido` with `encontrado`=1.
- Engines 1 and 3 both report distance 4 in the same pass → `quadranteEscolhido`=1; engine 0 reports 2, engine 3 reports 5 → engine 0 wins.
- Never any candidate, `operacaoFinalizada` stays 0 → radius climbs to 19, then `concluido` with `encontrado`=0 and `distanciaMinima`=8'hFF.
- All `operacaoFinalizada`=1 with no candidate at radius 2 → finish at radius 2 with `encontrado`=0.
- Drop `reset` low while in AGUARDA at radius 4 → all outputs 0 immediately (asynchronous); after release, `iniciar` at (0,19) starts cleanly with `raio`=1; an `iniciar` pulse while `ocupado`=1 is ignored.
